regfile_wb_arbiter: RTL and testbench

// Shares the single register-file write port (DR/data/ld) among NUM_REQ writeback sources
// (ALU, memory load, R7 link) with round-robin arbitration and a registered write stage.

---
 rtl/regfile_wb_arbiter.sv | 138 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the single register-file write port, plus a pending-write scoreboard and NZP generation.
// Latency: accepted request -> wr_en/wr_dr/wr_data/nzp registered on the next edge; hazards and grants are combinational.
// Backpressure: req_ready is a one-hot grant (none while hold=1); unaccepted requesters stall; rsv_ready drops when a counter is full.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [3*NUM_REQ-1:0]      req_dr,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      hold,
    input  logic                      rsv_valid,
    input  logic [2:0]                rsv_dr,
    output logic                      rsv_ready,
    input  logic [2:0]                chk_sr1,
    input  logic [2:0]                chk_sr2,
    output logic                      haz_sr1,
    output logic                      haz_sr2,
    output logic                      wr_en,
    output logic [2:0]                wr_dr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [2:0]                nzp
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  nxt_ptr;
    logic              gnt_found;
    logic              grant;
    logic [2:0]        sel_dr;
    logic [DATA_W-1:0] sel_data;
    logic [2:0]        sel_nzp;
    logic              rsv_acc;
    logic [7:0]        sb_inc;
    logic [7:0]        sb_dec;
    logic [CNT_W-1:0]  cnt [8];

    // Rotating priority search starting at rr_ptr; first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_found && req_valid[i] && ((int'(rr_ptr) + k) % NUM_REQ) == i) begin
                    gnt_found = 1'b1;
                    gnt_idx   = PTR_W'(i);
                end
            end
        end
    end

    assign grant   = gnt_found & ~hold;
    assign nxt_ptr = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

    // One-hot ready plus the winner's destination/data mux.
    always_comb begin
        req_ready = '0;
        sel_dr    = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                req_ready[i] = grant;
                sel_dr       = req_dr[3*i +: 3];
                sel_data     = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // Condition codes of the value about to be committed.
    always_comb begin
        if (sel_data[DATA_W-1])
            sel_nzp = 3'b100;
        else if (sel_data == '0)
            sel_nzp = 3'b010;
        else
            sel_nzp = 3'b001;
    end

    // A full counter can still accept when this cycle's grant retires one of its writes.
    assign rsv_ready = !((cnt[rsv_dr] == CNT_MAX) && !(grant && (sel_dr == rsv_dr)));
    assign rsv_acc   = rsv_valid & rsv_ready;

    // Per-register increment/decrement requests for the scoreboard.
    always_comb begin
        sb_inc = '0;
        sb_dec = '0;
        for (int r = 0; r < 8; r++) begin
            sb_inc[r] = rsv_acc && (rsv_dr == 3'(r));
            sb_dec[r] = grant && (sel_dr == 3'(r));
        end
    end

    // Pending-write counters; unreserved writes never underflow a zero count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 8; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 0; r < 8; r++) begin
                if (sb_inc[r] && !sb_dec[r])
                    cnt[r] <= cnt[r] + 1'b1;
                else if (sb_dec[r] && !sb_inc[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    // Registered write stage; without a grant only wr_en drops, the rest holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_dr   <= '0;
            wr_data <= '0;
            nzp     <= 3'b010;
            rr_ptr  <= '0;
        end else if (grant) begin
            wr_en   <= 1'b1;
            wr_dr   <= sel_dr;
            wr_data <= sel_data;
            nzp     <= sel_nzp;
            rr_ptr  <= nxt_ptr;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // The in-flight term covers the cycle before register_unit latches the value.
    assign haz_sr1 = (cnt[chk_sr1] != '0) | (wr_en & (wr_dr == chk_sr1));
    assign haz_sr2 = (cnt[chk_sr2] != '0) | (wr_en & (wr_dr == chk_sr2));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, NZP, scoreboard, hazards, hold and reset.
// Inputs change on the falling edge; combinational outputs are sampled 1ns later, registered ones 1ns after the rising edge.
// Every expectation below is a hand-computed constant.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [8:0]  req_dr;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        hold;
    logic        rsv_valid;
    logic [2:0]  rsv_dr;
    logic        rsv_ready;
    logic [2:0]  chk_sr1;
    logic [2:0]  chk_sr2;
    logic        haz_sr1;
    logic        haz_sr2;
    logic        wr_en;
    logic [2:0]  wr_dr;
    logic [15:0] wr_data;
    logic [2:0]  nzp;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(16), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_dr(req_dr), .req_data(req_data), .req_ready(req_ready),
        .hold(hold),
        .rsv_valid(rsv_valid), .rsv_dr(rsv_dr), .rsv_ready(rsv_ready),
        .chk_sr1(chk_sr1), .chk_sr2(chk_sr2), .haz_sr1(haz_sr1), .haz_sr2(haz_sr2),
        .wr_en(wr_en), .wr_dr(wr_dr), .wr_data(wr_data), .nzp(nzp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Change inputs just after the falling edge; comb outputs settle by +1ns.
    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic after_pos();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  exp_rdy [4];
        logic [2:0]  exp_dr  [4];

        reset     = 1'b1;
        req_valid = '0;
        req_dr    = '0;
        req_data  = '0;
        hold      = 1'b0;
        rsv_valid = 1'b0;
        rsv_dr    = '0;
        chk_sr1   = '0;
        chk_sr2   = '0;

        // Reset values
        #12;
        check("rst_wr_en",   wr_en,   0);
        check("rst_wr_dr",   wr_dr,   0);
        check("rst_wr_data", wr_data, 0);
        check("rst_nzp",     nzp,     3'b010);
        check("rst_haz1",    haz_sr1, 0);
        check("rst_haz2",    haz_sr2, 0);
        check("rst_ready",   req_ready, 0);
        at_neg();
        reset = 1'b0;

        // Round robin with all three valid: grants 0,1,2,0
        exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_dr  = '{3'd4, 3'd5, 3'd6, 3'd4};
        req_dr    = {3'd6, 3'd5, 3'd4};
        req_data  = {16'h0033, 16'h0022, 16'h0011};
        req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_ready", req_ready, exp_rdy[k]);
            after_pos();
            check("rr_wr_en", wr_en, 1);
            check("rr_wr_dr", wr_dr, exp_dr[k]);
            at_neg();
        end

        // NZP from committed data, requester 1 only (rr_ptr is 1 now)
        req_valid = 3'b010;
        req_dr    = {3'd6, 3'd3, 3'd4};
        req_data  = {16'h0033, 16'h8000, 16'h0011};
        #1;
        check("n_ready", req_ready, 3'b010);
        after_pos();
        check("n_wr_en",   wr_en,   1);
        check("n_wr_dr",   wr_dr,   3);
        check("n_wr_data", wr_data, 16'h8000);
        check("n_nzp",     nzp,     3'b100);
        at_neg();
        req_data[31:16] = 16'h0000;
        #1;
        check("z_ready", req_ready, 3'b010);
        after_pos();
        check("z_wr_data", wr_data, 0);
        check("z_nzp",     nzp,     3'b010);
        at_neg();
        req_data[31:16] = 16'h0001;
        after_pos();
        check("p_nzp", nzp, 3'b001);
        at_neg();
        req_valid = 3'b000;
        #1;
        check("idle_ready", req_ready, 0);
        after_pos();
        check("idle_wr_en",    wr_en,   0);
        check("idle_nzp_hold", nzp,     3'b001);
        check("idle_data_hold", wr_data, 16'h0001);

        // Scoreboard saturation on R5
        at_neg();
        chk_sr1   = 3'd5;
        rsv_valid = 1'b1;
        rsv_dr    = 3'd5;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rsv_ok", rsv_ready, 1);
            after_pos();
            check("rsv_haz", haz_sr1, 1);
            at_neg();
        end
        #1;
        check("rsv_full", rsv_ready, 0);
        at_neg();
        // Grant to R5 together with a reservation of R5 (rr_ptr=2 -> requester 0 wins)
        req_dr    = {3'd6, 3'd3, 3'd5};
        req_data  = {16'h0033, 16'h0001, 16'h0055};
        req_valid = 3'b001;
        #1;
        check("rsv_gnt_ready", req_ready, 3'b001);
        check("rsv_with_gnt",  rsv_ready, 1);
        after_pos();
        check("rsv_gnt_wr_dr", wr_dr, 5);
        at_neg();
        req_valid = 3'b000;
        #1;
        check("rsv_still_full", rsv_ready, 0);
        at_neg();
        rsv_valid = 1'b0;
        // Drain the three pending writes to R5
        req_valid = 3'b001;
        for (int k = 0; k < 3; k++) begin
            after_pos();
            check("drain_haz", haz_sr1, 1);
            at_neg();
        end
        req_valid = 3'b000;
        after_pos();
        check("drain_wr_en", wr_en,   0);
        check("drain_clear", haz_sr1, 0);

        // RAW hazard window on R2
        at_neg();
        chk_sr1 = 3'd2;
        chk_sr2 = 3'd2;
        #1;
        check("r2_pre_haz", haz_sr1, 0);
        rsv_valid = 1'b1;
        rsv_dr    = 3'd2;
        after_pos();
        check("r2_rsv_haz1", haz_sr1, 1);
        check("r2_rsv_haz2", haz_sr2, 1);
        at_neg();
        rsv_valid = 1'b0;
        req_dr    = {3'd2, 3'd3, 3'd5};
        req_data  = {16'hFFFF, 16'h0001, 16'h0055};
        req_valid = 3'b100;
        #1;
        check("r2_ready", req_ready, 3'b100);
        after_pos();
        check("r2_wr_dr",     wr_dr,   2);
        check("r2_nzp",       nzp,     3'b100);
        check("r2_inflight",  haz_sr1, 1);
        at_neg();
        req_valid = 3'b000;
        after_pos();
        check("r2_done_haz1", haz_sr1, 0);
        check("r2_done_haz2", haz_sr2, 0);

        // Hold freezes arbitration; rr_ptr is 0 after the requester-2 grant
        at_neg();
        req_dr    = {3'd6, 3'd5, 3'd4};
        req_data  = {16'h0033, 16'h0022, 16'h0011};
        req_valid = 3'b111;
        hold      = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("hold_ready", req_ready, 0);
            after_pos();
            check("hold_wr_en", wr_en, 0);
            check("hold_wr_dr", wr_dr, 2);
            at_neg();
        end
        hold      = 1'b0;
        rsv_valid = 1'b1;
        rsv_dr    = 3'd6;
        chk_sr1   = 3'd4;
        chk_sr2   = 3'd6;
        #1;
        check("resume_ready", req_ready, 3'b001);
        after_pos();
        check("resume_wr_en", wr_en, 1);
        check("resume_wr_dr", wr_dr, 4);
        check("resume_nzp",   nzp,   3'b001);
        check("pre_rst_haz1", haz_sr1, 1);
        check("pre_rst_haz2", haz_sr2, 1);

        // Asynchronous reset in the middle of the cycle
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_wr_en",   wr_en,   0);
        check("mid_rst_nzp",     nzp,     3'b010);
        check("mid_rst_wr_dr",   wr_dr,   0);
        check("mid_rst_wr_data", wr_data, 0);
        check("mid_rst_haz1",    haz_sr1, 0);
        check("mid_rst_haz2",    haz_sr2, 0);
        at_neg();
        reset     = 1'b0;
        rsv_valid = 1'b0;
        #1;
        // rr_ptr was 1 before reset; restart at requester 0
        check("post_rst_ready", req_ready, 3'b001);
        after_pos();
        check("post_rst_wr_dr", wr_dr, 4);
        at_neg();
        req_valid = 3'b000;
        after_pos();
        check("post_rst_haz2", haz_sr2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
